// File: rtl/dedup_stream_k.sv
// dedup_stream_k: streaming sorted-word filter keeping at most MAX_DUP
// copies per value, with a buffered result and registered read port.
module dedup_stream_k #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int MAX_DUP = 1,
    parameter int K_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [K_W-1:0]    rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [K_W-1:0]    k,
    output logic              done,
    output logic              overflow,
    output logic              unsorted_err
);

    localparam int R_W = $clog2(MAX_DUP + 1);
    localparam int A_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_ACCEPT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [K_W-1:0]    k_q;
    logic [R_W-1:0]    run_q;
    logic [DATA_W-1:0] last_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              done_q;
    logic              ovf_q;
    logic              uns_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic accept;
    logic same_val;
    logic keep;
    logic full;

    assign in_ready = (state_q == S_ACCEPT) & ~clear;
    assign accept   = in_valid & in_ready;
    assign same_val = (k_q != '0) && (in_data == last_q);
    assign keep     = !same_val || (run_q < R_W'(MAX_DUP));
    assign full     = (k_q == K_W'(DEPTH));

    // Kept-element storage; contents survive reset, only k bounds them.
    always_ff @(posedge clk) begin
        if (accept && keep && !full) begin
            mem_q[k_q[A_W-1:0]] <= in_data;
        end
    end

    // Frame control, keep/drop decision, sticky flags and read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_ACCEPT;
            k_q       <= '0;
            run_q     <= '0;
            last_q    <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            uns_q     <= 1'b0;
        end else begin
            if (rd_addr < k_q) begin
                rd_data_q <= mem_q[rd_addr[A_W-1:0]];
            end else begin
                rd_data_q <= '0;
            end
            if (clear) begin
                state_q <= S_ACCEPT;
                k_q     <= '0;
                run_q   <= '0;
                done_q  <= 1'b0;
                ovf_q   <= 1'b0;
                uns_q   <= 1'b0;
            end else if (accept) begin
                if (k_q != '0 && in_data < last_q) begin
                    uns_q <= 1'b1;
                end
                if (keep) begin
                    last_q <= in_data;
                    run_q  <= same_val ? run_q + 1'b1 : R_W'(1);
                    if (full) begin
                        ovf_q <= 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                if (in_last) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign rd_data      = rd_data_q;
    assign k            = k_q;
    assign done         = done_q;
    assign overflow     = ovf_q;
    assign unsorted_err = uns_q;

endmodule

// File: tb/tb_dedup_stream_k.sv
// tb_dedup_stream_k: directed bench for dedup_stream_k with three
// parameter sets driven from one shared stimulus bus.
module tb_dedup_stream_k;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [4:0]  rd_addr = '0;

    logic        r1, r2, r3;
    logic [31:0] d1, d2, d3;
    logic [4:0]  k1, k2;
    logic [2:0]  k3;
    logic        dn1, dn2, dn3;
    logic        o1, o2, o3;
    logic        e1, e2, e3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dedup_stream_k #(.DATA_W(32), .DEPTH(16), .MAX_DUP(1)) u1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_ready(r1), .in_data(in_data), .in_last(in_last),
        .rd_addr(rd_addr), .rd_data(d1), .k(k1), .done(dn1),
        .overflow(o1), .unsorted_err(e1)
    );

    dedup_stream_k #(.DATA_W(32), .DEPTH(16), .MAX_DUP(2)) u2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_ready(r2), .in_data(in_data), .in_last(in_last),
        .rd_addr(rd_addr), .rd_data(d2), .k(k2), .done(dn2),
        .overflow(o2), .unsorted_err(e2)
    );

    dedup_stream_k #(.DATA_W(32), .DEPTH(4), .MAX_DUP(1)) u3 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_ready(r3), .in_data(in_data), .in_last(in_last),
        .rd_addr(rd_addr[2:0]), .rd_data(d3), .k(k3), .done(dn3),
        .overflow(o3), .unsorted_err(e3)
    );

    task automatic send(input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++;
        if (k1 !== 5'd0 || dn1 !== 1'b0 || o1 !== 1'b0 ||
            e1 !== 1'b0 || d1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: k=%0d done=%b ovf=%b uns=%b rd=%0d expected all 0",
                     k1, dn1, o1, e1, d1);
        end
        checks++;
        if (r1 !== 1'b1 || r2 !== 1'b1 || r3 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b%b%b expected 111", r1, r2, r3);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_dedup1();
        logic [31:0] s [10] = '{0, 0, 1, 1, 1, 2, 2, 3, 3, 4};
        for (int i = 0; i < 9; i++) send(s[i], 1'b0);
        checks++;
        if (dn1 !== 1'b0) begin
            errors++;
            $display("FAIL dedup1_done_early: got %b expected 0", dn1);
        end
        send(s[9], 1'b1);
        checks++;
        if (dn1 !== 1'b1 || r1 !== 1'b0) begin
            errors++;
            $display("FAIL dedup1_done: done=%b ready=%b expected 1 0", dn1, r1);
        end
        checks++;
        if (k1 !== 5'd5 || o1 !== 1'b0 || e1 !== 1'b0) begin
            errors++;
            $display("FAIL dedup1_k: k=%0d ovf=%b uns=%b expected 5 0 0", k1, o1, e1);
        end
        for (int a = 0; a < 6; a++) begin
            rd_addr = 5'(a);
            @(posedge clk);
            #1;
            checks++;
            if (d1 !== ((a < 5) ? 32'(a) : 32'd0)) begin
                errors++;
                $display("FAIL dedup1_rd%0d: got %0d expected %0d",
                         a, d1, (a < 5) ? a : 0);
            end
        end
    endtask

    task automatic test_maxdup2();
        logic [31:0] s [6] = '{1, 1, 1, 2, 2, 3};
        logic [31:0] x [5] = '{1, 1, 2, 2, 3};
        do_clear();
        for (int i = 0; i < 6; i++) send(s[i], i == 5);
        checks++;
        if (k2 !== 5'd5 || o2 !== 1'b0 || e2 !== 1'b0 || dn2 !== 1'b1) begin
            errors++;
            $display("FAIL maxdup2_k: k=%0d ovf=%b uns=%b done=%b expected 5 0 0 1",
                     k2, o2, e2, dn2);
        end
        for (int a = 0; a < 5; a++) begin
            rd_addr = 5'(a);
            @(posedge clk);
            #1;
            checks++;
            if (d2 !== x[a]) begin
                errors++;
                $display("FAIL maxdup2_rd%0d: got %0d expected %0d", a, d2, x[a]);
            end
        end
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < 6; i++) begin
            send(32'(i), i == 5);
            checks++;
            if (k3 !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin
                errors++;
                $display("FAIL ovf_k_beat%0d: got %0d expected %0d",
                         i, k3, (i < 4) ? i + 1 : 4);
            end
        end
        checks++;
        if (o3 !== 1'b1 || dn3 !== 1'b1 || e3 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_flags: ovf=%b done=%b uns=%b expected 1 1 0", o3, dn3, e3);
        end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 5'(a);
            @(posedge clk);
            #1;
            checks++;
            if (d3 !== 32'(a)) begin
                errors++;
                $display("FAIL ovf_rd%0d: got %0d expected %0d", a, d3, a);
            end
        end
    endtask

    task automatic test_unsorted();
        do_clear();
        send(32'd3, 1'b0);
        checks++;
        if (e1 !== 1'b0) begin
            errors++;
            $display("FAIL uns_first: got %b expected 0", e1);
        end
        send(32'd1, 1'b0);
        checks++;
        if (e1 !== 1'b1) begin
            errors++;
            $display("FAIL uns_second: got %b expected 1", e1);
        end
        send(32'd1, 1'b1);
        checks++;
        if (k1 !== 5'd2 || e1 !== 1'b1) begin
            errors++;
            $display("FAIL uns_k: k=%0d uns=%b expected 2 1", k1, e1);
        end
        rd_addr = 5'd0;
        @(posedge clk);
        #1;
        checks++;
        if (d1 !== 32'd3) begin
            errors++;
            $display("FAIL uns_rd0: got %0d expected 3", d1);
        end
        rd_addr = 5'd1;
        @(posedge clk);
        #1;
        checks++;
        if (d1 !== 32'd1) begin
            errors++;
            $display("FAIL uns_rd1: got %0d expected 1", d1);
        end
    endtask

    task automatic test_handshake();
        do_clear();
        send(32'd10, 1'b0);
        idle($urandom_range(1, 3));
        send(32'd11, 1'b0);
        send(32'd12, 1'b0);
        idle($urandom_range(1, 3));
        send(32'd13, 1'b1);
        checks++;
        if (k1 !== 5'd4 || e1 !== 1'b0 || dn1 !== 1'b1) begin
            errors++;
            $display("FAIL hs_k: k=%0d uns=%b done=%b expected 4 0 1", k1, e1, dn1);
        end
        in_valid = 1'b1;
        in_data  = 32'd9;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (r1 !== 1'b0) begin
                errors++;
                $display("FAIL hs_done_ready%0d: got %b expected 0", i, r1);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (k1 !== 5'd4 || e1 !== 1'b0) begin
            errors++;
            $display("FAIL hs_done_hold: k=%0d uns=%b expected 4 0", k1, e1);
        end
        clear = 1'b1;
        #1;
        checks++;
        if (r1 !== 1'b0) begin
            errors++;
            $display("FAIL hs_clear_ready: got %b expected 0", r1);
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
        #1;
        checks++;
        if (k1 !== 5'd0 || dn1 !== 1'b0 || o1 !== 1'b0 ||
            e1 !== 1'b0 || r1 !== 1'b1 || o3 !== 1'b0) begin
            errors++;
            $display("FAIL hs_cleared: k=%0d done=%b ovf=%b uns=%b rdy=%b ovf3=%b expected 0 0 0 0 1 0",
                     k1, dn1, o1, e1, r1, o3);
        end
        send(32'd7, 1'b1);
        rd_addr = 5'd0;
        @(posedge clk);
        #1;
        checks++;
        if (k1 !== 5'd1 || d1 !== 32'd7) begin
            errors++;
            $display("FAIL hs_single: k=%0d rd=%0d expected 1 7", k1, d1);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        checks++;
        if (k1 !== 5'd3) begin
            errors++;
            $display("FAIL arst_pre: got %0d expected 3", k1);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (k1 !== 5'd0 || dn1 !== 1'b0 || o1 !== 1'b0 || e1 !== 1'b0) begin
            errors++;
            $display("FAIL arst_now: k=%0d done=%b ovf=%b uns=%b expected 0 0 0 0",
                     k1, dn1, o1, e1);
        end
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(32'd5, 1'b0);
        send(32'd5, 1'b1);
        checks++;
        if (k1 !== 5'd1 || dn1 !== 1'b1) begin
            errors++;
            $display("FAIL arst_after: k=%0d done=%b expected 1 1", k1, dn1);
        end
    endtask

    initial begin
        test_reset();
        test_dedup1();
        test_maxdup2();
        test_overflow();
        test_unsorted();
        test_handshake();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dedup_stream_k.md
Name: dedup_stream_k

Overview:
- Streaming, parametrised successor to the array-based remove-duplicates block.
- Accepts a framed stream of sorted unsigned words over a valid/ready handshake.
- Keeps at most MAX_DUP copies of each value: MAX_DUP=1 removes all duplicates; MAX_DUP=2 allows at most two copies.
- Stores kept elements in an internal buffer, then reports count k, done, and error flags. Results are read back through a registered read port.

Parameters:
DATA_W, 32, element width in bits
DEPTH, 16, capacity of the kept-element buffer (entries)
MAX_DUP, 1, maximum copies of one value retained; legal range >= 1
K_W, $clog2(DEPTH+1), width of k and rd_addr (derived; do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
clear  input  1  synchronous restart: empties buffer, zeroes k and flags, returns to ACCEPT
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_data  input  DATA_W  element value (unsigned)
in_last  input  1  final beat of the frame
rd_addr  input  K_W  buffer read index
rd_data  output  DATA_W  buffered element at rd_addr, registered
k  output  K_W  number of kept elements
done  output  1  frame complete; results valid
overflow  output  1  sticky: a keep was required while buffer full
unsorted_err  output  1  sticky: in_data < last kept value

Behaviour:
- Reset (rst=0, asynchronous): state=ACCEPT; k, done, overflow, unsorted_err, rd_data, run counter and last-kept register all 0. Buffer contents are not reset.
- FSM has two states, ACCEPT and DONE.
- in_ready = (state==ACCEPT) & ~clear. It is combinational, so it is 1 out of reset while clear=0.
- Accepted beat: in_valid & in_ready on a rising edge.
- Keep rule for each accepted beat:
  - If k==0 (no element kept yet in this frame) or in_data != last_kept: keep, run=1.
  - Else if run < MAX_DUP: keep, run=run+1.
  - Else: drop; no state change other than the last handling below.
  - Run counter width is $clog2(MAX_DUP+1).
- Keep action:
  - If k < DEPTH: buf[k] <= in_data, k <= k+1, last_kept <= in_data.
  - If k == DEPTH: no write; k saturates at DEPTH; overflow <= 1. last_kept and run still update, so later duplicates of that value are classified correctly.
- Sort check: if an element has been kept and in_data < last_kept (unsigned), unsorted_err <= 1. The beat is still processed by the keep rule.
- in_last on an accepted beat: the beat is processed normally, then state <= DONE. done=1 from the next cycle, and in_ready drops in the same cycle.
- DONE: no beats accepted; k and flags hold; done stays 1 until clear.
- clear (either state): next cycle k=0, done=0, overflow=0, unsorted_err=0, run=0, state=ACCEPT. While clear is high, in_ready=0, so no beat is lost or half-accepted.
- Read port, 1-cycle latency: rd_data <= (rd_addr < k) ? buf[rd_addr] : 0. Reads are legal in any state; the value reflects k at the sampling edge.
- Reset mid-frame: immediate abort to reset values; the partial frame is discarded.
- Empty frame does not exist: in_last always accompanies a real element. A single-beat frame gives k=1.
- Comparisons use full DATA_W unsigned. k arithmetic never wraps.

Test Plan:
1. MAX_DUP=1, DEPTH=16: stream 0,0,1,1,1,2,2,3,3,4 (last on 4), in_valid continuous.
   -> done rises one cycle after the last beat; k=5; rd_addr 0..4 returns 0,1,2,3,4 one cycle after each address; rd_addr 5 returns 0; flags 0.
2. MAX_DUP=2: stream 1,1,1,2,2,3 (last).
   -> k=5; buffer 1,1,2,2,3; overflow=0; unsorted_err=0.
3. DEPTH=4, MAX_DUP=1: stream 0,1,2,3,4,5 (last).
   -> k=4; buffer 0,1,2,3; overflow=1; done=1; k never exceeds 4.
4. MAX_DUP=1: stream 3,1,1 (last).
   -> unsorted_err=1 after the second beat; k=2; buffer 3,1.
5. Handshake: in_valid with in_valid toggling randomly.
   -> only beats with in_valid&in_ready counted.
   In DONE, hold in_valid=1 with data 9 for 5 cycles.
   -> in_ready=0; k unchanged.
   Pulse clear.
   -> k=0, done=0, flags 0, in_ready=1 next cycle.
   Stream single beat 7 with last.
   -> k=1, rd_data(0)=7.
6. Assert rst=0 asynchronously mid-frame after 3 kept beats, between clock edges.
   -> k, done and flags 0 immediately without a clock edge.
   Release and stream 5,5 (last).
   -> k=1.
